// File: rtl/dg0045_rom_server.sv
// Program-memory responder for the DG0045 core: scans the multiplexed PC, serves instruction bytes,
// and accepts a program image over a valid/ready load port. Optional macro: DG0045_ROM_QUAL_EN.
module dg0045_rom_server #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        pc_hl,
  output logic              pc_mux,
  output logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] addr_q,
  output logic              addr_valid,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready
);

  localparam int unsigned HALF_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {LO, HI, CMP, LOAD} state_t;

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   lo;
  logic [HALF_W-1:0]   hi;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   cand;
  logic                fresh;
  logic                settled;
  logic                cap_lo;
  logic                cap_hi;
  logic                apply;
  logic                cmp_done;
  logic                wr_en;
  logic                enter_load;
  logic                load_exit;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DG0045_ROM_QUAL_EN
  logic [ADDR_W-1:0]   prev;
`endif

  assign cand    = {hi, lo};
  assign settled = (cnt == CNT_W'(SETTLE));

  // Next-state and per-cycle strobes; load_start overrides every state.
  always_comb begin
    state_n    = state;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    apply      = 1'b0;
    cmp_done   = 1'b0;
    wr_en      = 1'b0;
    enter_load = 1'b0;
    load_exit  = 1'b0;
    if (load_start) begin
      state_n    = LOAD;
      enter_load = 1'b1;
    end else begin
      case (state)
        LO: begin
          if (settled) begin
            cap_lo  = 1'b1;
            state_n = HI;
          end
        end
        HI: begin
          if (settled) begin
            cap_hi  = 1'b1;
            state_n = CMP;
          end
        end
        CMP: begin
          cmp_done = 1'b1;
          state_n  = LO;
`ifdef DG0045_ROM_QUAL_EN
          apply = (cand == prev) && ((cand != addr_q) || fresh);
`else
          apply = (cand != addr_q) || fresh;
`endif
        end
        LOAD: begin
          wr_en = load_valid;
          if (load_end || (load_valid && (ptr == ADDR_W'(DEPTH - 1)))) begin
            load_exit = 1'b1;
            state_n   = LO;
          end
        end
        default: state_n = LO;
      endcase
    end
  end

  // State register plus scan/load datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LO;
      cnt        <= '0;
      lo         <= '0;
      hi         <= '0;
      ptr        <= '0;
      fresh      <= 1'b1;
      pc_mux     <= 1'b0;
      rom_data   <= '0;
      addr_q     <= '0;
      addr_valid <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state      <= state_n;
      pc_mux     <= (state_n == HI);
      load_ready <= (state_n == LOAD);
      addr_valid <= apply;
      cnt        <= ((state_n == state) && ((state == LO) || (state == HI))) ? cnt + CNT_W'(1) : '0;
      if (cap_lo) lo <= pc_hl;
      if (cap_hi) hi <= pc_hl;
      if (apply) begin
        addr_q   <= cand;
        rom_data <= mem[cand];
        fresh    <= 1'b0;
      end
      if (enter_load) rom_data <= '0;
      if (enter_load)  ptr <= '0;
      else if (wr_en)  ptr <= ptr + ADDR_W'(1);
      // A new image invalidates the served byte, so force the next scan to refresh it.
      if (load_exit) begin
        ptr   <= '0;
        fresh <= 1'b1;
      end
    end
  end

`ifdef DG0045_ROM_QUAL_EN
  // Last scanned candidate, used to require two identical scans before applying.
  always_ff @(posedge clk) begin
    if (!rst_n)         prev <= '0;
    else if (load_exit) prev <= '0;
    else if (cmp_done)  prev <= cand;
  end
`endif

  // Program array has no reset so the image survives a reset pulse.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[ptr] <= load_data;
  end

endmodule

// File: tb/tb_dg0045_rom_server.sv
// Self-checking bench for dg0045_rom_server: emulates the core's PC mux and compares served bytes
// against a reference image and the address-change / latency rules.
module tb_dg0045_rom_server;

  localparam int unsigned T_SCAN = 3;
`ifdef DG0045_ROM_QUAL_EN
  localparam int LAT = 3 * T_SCAN;
`else
  localparam int LAT = 2 * T_SCAN;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [7:0] rom_data;
  logic [9:0] addr_q;
  logic       addr_valid;
  logic       load_start;
  logic       load_end;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;

  logic [9:0] pc;
  logic [7:0] ref_mem [1024];

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  ev_t ev_q[$];

  int checks;
  int errors;
  int cyc;

  dg0045_rom_server #(.ADDR_W(10), .DEPTH(1024), .SETTLE(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_hl      (pc_hl),
    .pc_mux     (pc_mux),
    .rom_data   (rom_data),
    .addr_q     (addr_q),
    .addr_valid (addr_valid),
    .load_start (load_start),
    .load_end   (load_end),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready)
  );

  // Core side: the PC half on pc_hl follows the select combinationally.
  assign pc_hl = pc_mux ? pc[9:5] : pc[4:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (addr_valid === 1'b1) ev_q.push_back('{addr: addr_q, data: rom_data, cyc: cyc});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic int count_addr(input logic [9:0] a);
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i].addr == a) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    run(2);
    checks++; if (pc_mux !== 1'b0) begin errors++; $display("FAIL reset_pc_mux got %b exp 0", pc_mux); end
    checks++; if (rom_data !== 8'h00) begin errors++; $display("FAIL reset_rom_data got %h exp 00", rom_data); end
    checks++; if (addr_q !== 10'h000) begin errors++; $display("FAIL reset_addr_q got %h exp 000", addr_q); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_addr_valid got %b exp 0", addr_valid); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b exp 0", load_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_basic();
    logic [7:0] b [3];
    int start;
    b[0] = 8'h80; b[1] = 8'h55; b[2] = 8'h3A;
    pc = 10'h002;
    run(4);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL basic_load_ready got %b exp 1", load_ready); end
    checks++; if (rom_data !== 8'h00) begin errors++; $display("FAIL basic_load_nop got %h exp 00", rom_data); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = b[i];
      load_end   = (i == 2);
      ref_mem[i] = b[i];
      tick();
    end
    load_valid = 1'b0;
    load_end   = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL basic_load_exit got %b exp 0", load_ready); end
    ev_q.delete();
    start = cyc;
    run(4 * T_SCAN);
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++; if (ev_q[0].addr !== 10'h002) begin errors++; $display("FAIL basic_ev_addr got %h exp 002", ev_q[0].addr); end
      checks++; if (ev_q[0].data !== 8'h3A) begin errors++; $display("FAIL basic_ev_data got %h exp 3A", ev_q[0].data); end
      checks++; if (ev_q[0].cyc - start > LAT) begin errors++; $display("FAIL basic_latency got %0d exp <=%0d", ev_q[0].cyc - start, LAT); end
    end
    checks++; if (addr_q !== 10'h002) begin errors++; $display("FAIL basic_addr_q got %h exp 002", addr_q); end
    checks++; if (rom_data !== 8'h3A) begin errors++; $display("FAIL basic_rom_data got %h exp 3A", rom_data); end
  endtask

  task automatic test_full_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      ref_mem[i] = load_data;
      tick();
      if (i == 1022) begin
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL full_ready_1022 got %b exp 1", load_ready); end
      end
    end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_auto_exit got %b exp 0", load_ready); end
    load_valid = 1'b0;
    pc = 10'h3FF;
    ev_q.delete();
    run(4 * T_SCAN);
    checks++; if (count_addr(10'h3FF) != 1) begin errors++; $display("FAIL full_pulse_3ff got %0d exp 1", count_addr(10'h3FF)); end
    checks++; if (rom_data !== ref_mem[1023]) begin errors++; $display("FAIL full_mem_1023 got %h exp %h", rom_data, ref_mem[1023]); end
    checks++; if (addr_q !== 10'h3FF) begin errors++; $display("FAIL full_addr_q got %h exp 3ff", addr_q); end
  endtask

  task automatic test_pc_stepping();
    int p;
    int start;
    int idx;
    pc = 10'h000;
    run(4 * T_SCAN);
    p = 0;
    for (int s = 0; s < 80 && p != 'h3C1; s++) begin
      p = p + int'($urandom_range(1, 48));
      if (p >= 'h3C1) p = 'h3C1;
      pc = 10'(p);
      ev_q.delete();
      start = cyc;
      run(8);
      checks++; if (count_addr(pc) != 1) begin errors++; $display("FAIL step_pulses pc %h got %0d exp 1", pc, count_addr(pc)); end
`ifdef DG0045_ROM_QUAL_EN
      checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL step_total pc %h got %0d exp 1", pc, ev_q.size()); end
`endif
      idx = -1;
      foreach (ev_q[i]) if (idx < 0 && ev_q[i].addr == pc) idx = i;
      if (idx >= 0) begin
        checks++; if (ev_q[idx].data !== ref_mem[pc]) begin errors++; $display("FAIL step_data pc %h got %h exp %h", pc, ev_q[idx].data, ref_mem[pc]); end
        checks++; if (ev_q[idx].cyc - start > LAT) begin errors++; $display("FAIL step_latency pc %h got %0d exp <=%0d", pc, ev_q[idx].cyc - start, LAT); end
      end
      checks++; if (rom_data !== ref_mem[pc]) begin errors++; $display("FAIL step_rom_data pc %h got %h exp %h", pc, rom_data, ref_mem[pc]); end
    end
    checks++; if (addr_q !== 10'h3C1) begin errors++; $display("FAIL step_final_addr got %h exp 3c1", addr_q); end
  endtask

  task automatic test_torn();
    int w;
    pc = 10'h000;
    run(4 * T_SCAN);
    ev_q.delete();
    w = 0;
    while (pc_mux !== 1'b1 && w < 10) begin tick(); w++; end
    checks++; if (w >= 10) begin errors++; $display("FAIL torn_wait_hi got timeout exp pc_mux=1"); end
    // lo of 0x000 is already captured; hi of 0x3FF will be, giving 0x3E0 for one scan.
    pc = 10'h3FF;
    run(15);
`ifdef DG0045_ROM_QUAL_EN
    checks++; if (count_addr(10'h3E0) != 0) begin errors++; $display("FAIL torn_applied got %0d exp 0", count_addr(10'h3E0)); end
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL torn_total got %0d exp 1", ev_q.size()); end
`else
    checks++; if (count_addr(10'h3E0) != 1) begin errors++; $display("FAIL torn_applied got %0d exp 1", count_addr(10'h3E0)); end
    if (ev_q.size() > 0) begin
      checks++; if (ev_q[0].data !== ref_mem[10'h3E0]) begin errors++; $display("FAIL torn_data got %h exp %h", ev_q[0].data, ref_mem[10'h3E0]); end
    end
`endif
    checks++; if (count_addr(10'h3FF) != 1) begin errors++; $display("FAIL torn_final_pulse got %0d exp 1", count_addr(10'h3FF)); end
    checks++; if (rom_data !== ref_mem[1023]) begin errors++; $display("FAIL torn_final_data got %h exp %h", rom_data, ref_mem[1023]); end
  endtask

  task automatic test_load_restart();
    int w;
    logic [7:0] d0;
    logic [7:0] d1;
    d0 = ref_mem[0] ^ 8'h5A;
    d1 = 8'($urandom);
    w = 0;
    while (pc_mux !== 1'b1 && w < 10) begin tick(); w++; end
    checks++; if (w >= 10) begin errors++; $display("FAIL restart_wait_hi got timeout exp pc_mux=1"); end
    load_start = 1'b1;
    tick();
    checks++; if (pc_mux !== 1'b0) begin errors++; $display("FAIL restart_pc_mux got %b exp 0", pc_mux); end
    checks++; if (rom_data !== 8'h00) begin errors++; $display("FAIL restart_nop got %h exp 00", rom_data); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b exp 1", load_ready); end
    load_valid = 1'b1;
    load_data  = ~d0;
    tick();
    load_start = 1'b0;
    load_data  = d0;
    tick();
    load_data  = d1;
    load_end   = 1'b1;
    tick();
    load_valid = 1'b0;
    load_end   = 1'b0;
    ref_mem[0] = d0;
    ref_mem[1] = d1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL restart_exit got %b exp 0", load_ready); end
    pc = 10'h000;
    ev_q.delete();
    run(4 * T_SCAN);
    checks++; if (count_addr(10'h000) != 1) begin errors++; $display("FAIL restart_force_pulse got %0d exp 1", count_addr(10'h000)); end
    checks++; if (rom_data !== d0) begin errors++; $display("FAIL restart_mem0 got %h exp %h", rom_data, d0); end
    pc = 10'h001;
    run(4 * T_SCAN);
    checks++; if (rom_data !== d1) begin errors++; $display("FAIL restart_mem1 got %h exp %h", rom_data, d1); end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      ref_mem[i] = load_data;
      tick();
    end
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_still_loading got %b exp 1", load_ready); end
    rst_n = 1'b0;
    tick();
    checks++; if (pc_mux !== 1'b0) begin errors++; $display("FAIL rst_mid_pc_mux got %b exp 0", pc_mux); end
    checks++; if (rom_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rom_data got %h exp 00", rom_data); end
    checks++; if (addr_q !== 10'h000) begin errors++; $display("FAIL rst_mid_addr_q got %h exp 000", addr_q); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_addr_valid got %b exp 0", addr_valid); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_load_ready got %b exp 0", load_ready); end
    rst_n = 1'b1;
    pc = 10'h005;
    ev_q.delete();
    run(4 * T_SCAN);
    checks++; if (count_addr(10'h005) != 1) begin errors++; $display("FAIL rst_mid_pulse got %0d exp 1", count_addr(10'h005)); end
    checks++; if (rom_data !== ref_mem[5]) begin errors++; $display("FAIL rst_mid_mem5 got %h exp %h", rom_data, ref_mem[5]); end
    pc = 10'h009;
    run(4 * T_SCAN);
    checks++; if (rom_data !== ref_mem[9]) begin errors++; $display("FAIL rst_mid_mem9 got %h exp %h", rom_data, ref_mem[9]); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    pc         = 10'h000;
    load_start = 1'b0;
    load_end   = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    test_reset();
    test_load_basic();
    test_full_load();
    test_pc_stepping();
    test_torn();
    test_load_restart();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
